// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Desc     : Shared constants, mode encoding and helpers for mux_nx1_rr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Index width that still gives a 1-bit select for a two-channel mux
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin search from ptr+1 (wrapping, ptr last) -> one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] idx
);

  int   w_cand;
  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = (int'(ptr) + k) % N_CH;
      if (!w_found && req[w_cand]) begin
        w_found        = 1'b1;
        grant[w_cand]  = 1'b1;
        idx            = SEL_W'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_nx1_rr.sv
// ============================================================================
// Module   : mux_nx1_rr
// Desc     : N-to-1 valid/ready mux, manual or round-robin select, 1-cycle reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  logic [SEL_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_ch;

  logic              w_load_en;
  logic [N_CH-1:0]   w_rr_grant;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [N_CH-1:0]   w_man_grant;
  logic [SEL_W-1:0]  w_man_idx;
  logic [N_CH-1:0]   w_grant;
  logic [SEL_W-1:0]  w_idx;
  logic              w_take;
  logic [DATA_W-1:0] w_mux_data;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_rr_grant),
    .idx   (w_rr_idx)
  );

  // An out-of-range sel simply matches no channel
  always_comb begin
    w_man_grant = '0;
    w_man_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if ((int'(sel) == i) && in_valid[i]) begin
        w_man_grant[i] = 1'b1;
        w_man_idx      = SEL_W'(i);
      end
    end
  end

  assign w_load_en = !r_out_valid || out_ready;

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    if (rst_n && w_load_en) begin
      if (mode == MODE_RR) begin
        w_grant = w_rr_grant;
        w_idx   = w_rr_idx;
      end else begin
        w_grant = w_man_grant;
        w_idx   = w_man_idx;
      end
    end
  end

  assign w_take   = |w_grant;
  assign in_ready = w_grant;

  // AND-OR mux keyed on the one-hot grant
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant[i]) begin
        w_mux_data = w_mux_data | in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SEL_W'(N_CH - 1);
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_ch    <= w_idx;
      r_ptr       <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule

`default_nettype wire
